// File: rtl/serial_paralelo_rx_pkg.sv
// Shared constants for the per-lane receive deserializer: COM symbol, lock depth
// and the state encoding used by serial_paralelo_rx.
package serial_paralelo_rx_pkg;

    typedef logic [1:0] rx_state_t;

    localparam logic [7:0] COM_SYMBOL_DEF = 8'hBC;
    localparam int         BC_LOCK_DEF    = 4;

    localparam rx_state_t ST_SEARCH  = 2'd0;
    localparam rx_state_t ST_LOCKING = 2'd1;
    localparam rx_state_t ST_ACTIVE  = 2'd2;

endpackage

// File: rtl/serial_paralelo_rx_rx_byte_framer.sv
// Serial-to-byte framer: MSB-first shift register plus a wrapping bit counter
// whose phase can be forced back to zero when a new byte alignment is found.
module rx_byte_framer (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       i_data_in,
    input  logic       i_realign,
    output logic [7:0] o_cand,
    output logic       o_boundary
);

    logic [7:0] r_shift;
    logic [2:0] r_bit_cnt;

    // cand includes the bit being sampled this edge, so a full byte is visible on its LSB edge
    assign o_cand     = {r_shift[6:0], i_data_in};
    assign o_boundary = (r_bit_cnt == 3'd7);

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            r_shift   <= 8'h00;
            r_bit_cnt <= 3'd0;
        end else begin
            r_shift   <= o_cand;
            r_bit_cnt <= i_realign ? 3'd0 : r_bit_cnt + 3'd1;
        end
    end

endmodule

// File: rtl/serial_paralelo_rx.sv
// Per-lane receive deserializer: hunts for COM alignment, locks, then emits bytes.
// Optional macro SP_RX_IDLE_CNT_EN adds a saturating idle_count output.
module serial_paralelo_rx
    import serial_paralelo_rx_pkg::*;
#(
    parameter logic [7:0] COM_SYMBOL = COM_SYMBOL_DEF,
    parameter int         BC_LOCK    = BC_LOCK_DEF
) (
    input  logic        clk_32f,
    input  logic        reset,
    input  logic        data_in,
    output logic [7:0]  data_out,
    output logic        valid_out,
    output logic        active
`ifdef SP_RX_IDLE_CNT_EN
    ,
    output logic [15:0] idle_count
`endif
);

    localparam logic [2:0] LP_BC_LOCK = 3'(BC_LOCK);

    rx_state_t  r_state;
    logic [2:0] r_bc_cnt;
    logic [7:0] r_data_out;
    logic       r_valid_out;

    logic [7:0] w_cand;
    logic       w_boundary;
    logic       w_is_com;
    logic       w_realign;

    assign w_is_com  = (w_cand == COM_SYMBOL);
    assign w_realign = (r_state == ST_SEARCH) && w_is_com;

    rx_byte_framer u_framer (
        .clk_32f    (clk_32f),
        .reset      (reset),
        .i_data_in  (data_in),
        .i_realign  (w_realign),
        .o_cand     (w_cand),
        .o_boundary (w_boundary)
    );

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_SEARCH;
            r_bc_cnt    <= 3'd0;
            r_data_out  <= 8'h00;
            r_valid_out <= 1'b0;
        end else begin
            case (r_state)
                ST_SEARCH: begin
                    if (w_is_com) begin
                        r_bc_cnt <= 3'd1;
                        r_state  <= (LP_BC_LOCK == 3'd1) ? ST_ACTIVE : ST_LOCKING;
                    end
                end
                ST_LOCKING: begin
                    if (w_boundary) begin
                        if (w_is_com) begin
                            r_bc_cnt <= r_bc_cnt + 3'd1;
                            if (r_bc_cnt + 3'd1 == LP_BC_LOCK) begin
                                r_state <= ST_ACTIVE;
                            end
                        end else begin
                            r_bc_cnt <= 3'd0;
                            r_state  <= ST_SEARCH;
                        end
                    end
                end
                ST_ACTIVE: begin
                    // Idle COMs drop valid but leave the last real byte on data_out
                    if (w_boundary) begin
                        if (w_is_com) begin
                            r_valid_out <= 1'b0;
                        end else begin
                            r_data_out  <= w_cand;
                            r_valid_out <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_SEARCH;
                end
            endcase
        end
    end

    assign data_out  = r_data_out;
    assign valid_out = r_valid_out;
    assign active    = (r_state == ST_ACTIVE);

`ifdef SP_RX_IDLE_CNT_EN
    logic [15:0] r_idle_count;

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            r_idle_count <= 16'h0000;
        end else if ((r_state == ST_ACTIVE) && w_boundary && w_is_com
                     && (r_idle_count != 16'hFFFF)) begin
            r_idle_count <= r_idle_count + 16'd1;
        end
    end

    assign idle_count = r_idle_count;
`endif

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// Directed, scoreboard-based bench for serial_paralelo_rx (checks every bit time).
module tb_serial_paralelo_rx;

    logic        clk_32f;
    logic        reset;
    logic        data_in;
    logic [7:0]  data_out;
    logic        valid_out;
    logic        active;
`ifdef SP_RX_IDLE_CNT_EN
    logic [15:0] idle_count;
`endif

    serial_paralelo_rx dut (
        .clk_32f   (clk_32f),
        .reset     (reset),
        .data_in   (data_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .active    (active)
`ifdef SP_RX_IDLE_CNT_EN
        ,
        .idle_count(idle_count)
`endif
    );

    initial clk_32f = 1'b0;
    always #5 clk_32f = ~clk_32f;

    typedef struct packed {
        logic       v;
        logic [7:0] d;
        logic       a;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, ".data_out"},  {8'h00, data_out},   {8'h00, cur.d});
        chk({tag, ".valid_out"}, {15'h0, valid_out},  {15'h0, cur.v});
        chk({tag, ".active"},    {15'h0, active},     {15'h0, cur.a});
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk_32f);
        data_in = b;
        @(posedge clk_32f);
        #1;
    endtask

    // Expected output for a byte is pushed before driving and popped on its LSB edge
    task automatic push(input logic v, input logic [7:0] d, input logic a);
        exp_t e;
        e.v = v; e.d = d; e.a = a;
        sb.push_back(e);
    endtask

    task automatic send_byte(input string tag, input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            send_bit(b[i]);
            if (i == 0) begin
                checks++;
                assert (sb.size() != 0) else begin
                    errors++;
                    $error("FAIL %s scoreboard empty got=0 exp=1", tag);
                end
                if (sb.size() != 0) cur = sb.pop_front();
            end
            chk_outputs(tag);
        end
        $display("byte %s sent=%h data_out=%h valid_out=%b active=%b",
                 tag, b, data_out, valid_out, active);
    endtask

    task automatic hold_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_32f);
            data_in = i[0];
            @(posedge clk_32f);
            #1;
            chk_outputs("in_reset");
        end
    endtask

    initial begin
        cur     = '0;
        reset   = 1'b0;
        data_in = 1'b0;
        #1;
        chk_outputs("reset_async");
        hold_reset(5);
        reset = 1'b1;

        // Lock at a 3-bit offset, then data / data / idle
        send_bit(1'b1); chk_outputs("junk");
        send_bit(1'b0); chk_outputs("junk");
        send_bit(1'b1); chk_outputs("junk");
        push(1'b0, 8'h00, 1'b0); send_byte("lock1", 8'hBC);
        push(1'b0, 8'h00, 1'b0); send_byte("lock2", 8'hBC);
        push(1'b0, 8'h00, 1'b0); send_byte("lock3", 8'hBC);
        push(1'b0, 8'h00, 1'b1); send_byte("lock4", 8'hBC);
        push(1'b1, 8'hA5, 1'b1); send_byte("dataA5", 8'hA5);
        push(1'b1, 8'h3C, 1'b1); send_byte("data3C", 8'h3C);
        push(1'b0, 8'h3C, 1'b1); send_byte("idle", 8'hBC);

        // Asynchronous reset at bit 4 of 0x5A while ACTIVE
        send_bit(1'b0); chk_outputs("pre_rst");
        send_bit(1'b1); chk_outputs("pre_rst");
        send_bit(1'b0); chk_outputs("pre_rst");
        send_bit(1'b1); chk_outputs("pre_rst");
        #2;
        reset = 1'b0;
        #1;
        cur = '0;
        chk_outputs("mid_reset");
        hold_reset(2);
        reset = 1'b1;

        // Failed lock: three COMs then a non-COM
        push(1'b0, 8'h00, 1'b0); send_byte("fl1", 8'hBC);
        push(1'b0, 8'h00, 1'b0); send_byte("fl2", 8'hBC);
        push(1'b0, 8'h00, 1'b0); send_byte("fl3", 8'hBC);
        push(1'b0, 8'h00, 1'b0); send_byte("fl_break", 8'h00);
        push(1'b0, 8'h00, 1'b0); send_byte("rl1", 8'hBC);
        push(1'b0, 8'h00, 1'b0); send_byte("rl2", 8'hBC);
        push(1'b0, 8'h00, 1'b0); send_byte("rl3", 8'hBC);
        push(1'b0, 8'h00, 1'b1); send_byte("rl4", 8'hBC);
        push(1'b1, 8'h5A, 1'b1); send_byte("data5A", 8'h5A);
        push(1'b0, 8'h5A, 1'b1); send_byte("idle2", 8'hBC);

`ifdef SP_RX_IDLE_CNT_EN
        chk("idle_count_1", idle_count, 16'd1);
        for (int i = 0; i < 9; i++) begin
            push(1'b0, 8'h5A, 1'b1); send_byte("idle_run", 8'hBC);
        end
        chk("idle_count_10", idle_count, 16'd10);
        push(1'b1, 8'h11, 1'b1); send_byte("data11", 8'h11);
        chk("idle_count_hold", idle_count, 16'd10);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
